data_sram_responder: RTL and testbench

Slave end of the data-SRAM request/response interface that the EX stage drives and the MEM stage consumes through `data_sram_rdata`. It accepts requests with an `addr_ok` handshake, performs byte-strobed writes or word reads on an internal word-addressed memory, and returns in-order responses on `data_ok`/`rdata` after a programmable latency. It serves as the data-memory model in the CPU testbench and in FPGA bring-up.

---
 rtl/data_sram_responder.sv | 111 +++++++++++
 tb/tb_data_sram_responder.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_sram_responder.sv
// rtl/data_sram_responder.sv - Data-SRAM slave: byte-strobed writes, word reads, in-order fixed-latency responses
module data_sram_responder #(
    parameter int ADDR_WIDTH      = 10,
    parameter int ACCEPT_DELAY    = 0,
    parameter int DATA_LATENCY    = 2,
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        wr,
    input  logic [1:0]  size,
    input  logic [31:0] addr,
    input  logic [3:0]  wstrb,
    input  logic [31:0] wdata,
    output logic        addr_ok,
    output logic        data_ok,
    output logic [31:0] rdata
);
    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam int PW    = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int CW    = $clog2(MAX_OUTSTANDING + 1);
    localparam int TW    = $clog2(DATA_LATENCY + 1);
    localparam int WW    = $clog2(ACCEPT_DELAY + 2);

    localparam logic [CW-1:0] MAX_CNT    = CW'(MAX_OUTSTANDING);
    localparam logic [TW-1:0] TIMER_INIT = TW'(DATA_LATENCY - 1);
    localparam logic [WW-1:0] WAIT_MAX   = WW'(ACCEPT_DELAY);
    localparam logic [PW-1:0] LAST_PTR   = PW'(MAX_OUTSTANDING - 1);

    logic [31:0]                mem [DEPTH];
    logic [ADDR_WIDTH-1:0]      idx;
    logic [CW-1:0]              count;
    logic [PW-1:0]              head;
    logic [PW-1:0]              tail;
    logic [WW-1:0]              wait_cnt;
    logic                       delay_met;
    logic [MAX_OUTSTANDING-1:0] q_valid;
    logic [31:0]                q_data  [MAX_OUTSTANDING];
    logic [TW-1:0]              q_timer [MAX_OUTSTANDING];
    logic                       push;
    logic                       pop;
    logic                       unused_ok;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == LAST_PTR) ? '0 : p + PW'(1);
    endfunction

    assign idx       = addr[ADDR_WIDTH+1:2];
    assign unused_ok = ^{size, addr[31:ADDR_WIDTH+2], addr[1:0]};

    // wait_cnt saturates at ACCEPT_DELAY, so equality is the same as reaching it
    assign delay_met = (wait_cnt == WAIT_MAX);
    assign addr_ok   = !reset && req && (count < MAX_CNT) && delay_met;
    assign data_ok   = !reset && q_valid[head] && (q_timer[head] == '0);
    assign rdata     = data_ok ? q_data[head] : 32'd0;
    assign push      = addr_ok;
    assign pop       = data_ok;

    always_ff @(posedge clk) begin
        if (reset) begin
            count    <= '0;
            head     <= '0;
            tail     <= '0;
            wait_cnt <= '0;
            q_valid  <= '0;
        end else begin
            if (!req || push) begin
                wait_cnt <= '0;
            end else if (wait_cnt != WAIT_MAX) begin
                wait_cnt <= wait_cnt + WW'(1);
            end
            if (push && !pop) begin
                count <= count + CW'(1);
            end else if (pop && !push) begin
                count <= count - CW'(1);
            end
            if (pop) begin
                q_valid[head] <= 1'b0;
                head          <= next_ptr(head);
            end
            if (push) begin
                q_valid[tail] <= 1'b1;
                tail          <= next_ptr(tail);
            end
        end
    end

    // Write responses carry zero data so rdata needs no read/write qualifier
    always_ff @(posedge clk) begin
        for (int i = 0; i < MAX_OUTSTANDING; i++) begin
            if (q_valid[i] && q_timer[i] != '0) begin
                q_timer[i] <= q_timer[i] - TW'(1);
            end
        end
        if (push) begin
            q_data[tail]  <= wr ? 32'd0 : mem[idx];
            q_timer[tail] <= TIMER_INIT;
        end
    end

    always_ff @(posedge clk) begin
        if (push && wr) begin
            for (int b = 0; b < 4; b++) begin
                if (wstrb[b]) begin
                    mem[idx][8*b +: 8] <= wdata[8*b +: 8];
                end
            end
        end
    end
endmodule

// File: tb/tb_data_sram_responder.sv
// tb/tb_data_sram_responder.sv - Three parameterisations driven concurrently and checked against a cycle-schedule model
module tb_data_sram_responder;
    localparam int N = 3;

    typedef struct packed {
        logic [1:0]  kind;   // 0 request, 1 idle cycle, 2 request abandoned after hold cycles
        logic        wr;
        logic [31:0] addr;
        logic [3:0]  strb;
        logic [31:0] data;
        logic [7:0]  hold;
    } rq_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        req     [N];
    logic        wr      [N];
    logic [1:0]  size    [N];
    logic [31:0] addr    [N];
    logic [3:0]  wstrb   [N];
    logic [31:0] wdata   [N];
    logic        addr_ok [N];
    logic        data_ok [N];
    logic [31:0] rdata   [N];

    always #5 clk = ~clk;

    data_sram_responder #(.ADDR_WIDTH(10), .ACCEPT_DELAY(0), .DATA_LATENCY(2), .MAX_OUTSTANDING(2)) dut0 (
        .clk(clk), .reset(reset), .req(req[0]), .wr(wr[0]), .size(size[0]), .addr(addr[0]),
        .wstrb(wstrb[0]), .wdata(wdata[0]), .addr_ok(addr_ok[0]), .data_ok(data_ok[0]), .rdata(rdata[0]));
    data_sram_responder #(.ADDR_WIDTH(4), .ACCEPT_DELAY(0), .DATA_LATENCY(3), .MAX_OUTSTANDING(2)) dut1 (
        .clk(clk), .reset(reset), .req(req[1]), .wr(wr[1]), .size(size[1]), .addr(addr[1]),
        .wstrb(wstrb[1]), .wdata(wdata[1]), .addr_ok(addr_ok[1]), .data_ok(data_ok[1]), .rdata(rdata[1]));
    data_sram_responder #(.ADDR_WIDTH(6), .ACCEPT_DELAY(2), .DATA_LATENCY(1), .MAX_OUTSTANDING(1)) dut2 (
        .clk(clk), .reset(reset), .req(req[2]), .wr(wr[2]), .size(size[2]), .addr(addr[2]),
        .wstrb(wstrb[2]), .wdata(wdata[2]), .addr_ok(addr_ok[2]), .data_ok(data_ok[2]), .rdata(rdata[2]));

    function automatic int lat_of(int i);
        case (i)
            0:       return 2;
            1:       return 3;
            default: return 1;
        endcase
    endfunction
    function automatic int max_of(int i); return (i == 2) ? 1 : 2; endfunction
    function automatic int dly_of(int i); return (i == 2) ? 2 : 0; endfunction
    function automatic int aw_of(int i);
        case (i)
            0:       return 10;
            1:       return 4;
            default: return 6;
        endcase
    endfunction

    // Reference state: memory image, accept history and a response schedule keyed by cycle number
    logic [31:0] mem_m    [N][1024];
    bit          acc_hist [N][64];
    bit          sch_v    [N][64];
    bit          sch_r    [N][64];
    logic [31:0] sch_d    [N][64];
    int          streak   [N];
    int          cyc;

    rq_t rq     [N][256];
    int  rq_wr  [N];
    int  rq_rd  [N];
    bit  busy   [N];
    rq_t cur    [N];
    int  held   [N];
    int  ld_cyc [N];

    int          acc_n [N];
    int          acc_c [N][256];
    int          dok_n [N];
    int          dok_c [N][256];
    logic [31:0] rd_last [N];

    int vectors;
    int miscompares;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic int widx(int i, logic [31:0] a);
        return int'((a >> 2) & ((32'd1 << aw_of(i)) - 32'd1));
    endfunction

    function automatic logic [31:0] mk_addr(int i, int w);
        logic [31:0] m;
        m = ((32'd1 << aw_of(i)) - 32'd1) << 2;
        return ($urandom() & ~m) | (32'(w) << 2);
    endfunction

    function automatic int ac(int i, int n); return acc_c[i][n % 256]; endfunction
    function automatic int dc(int i, int n); return dok_c[i][n % 256]; endfunction

    task automatic push(input int i, input logic [1:0] kind, input logic w, input logic [31:0] a,
                        input logic [3:0] s, input logic [31:0] d, input int h);
        rq_t e;
        e.kind = kind; e.wr = w; e.addr = a; e.strb = s; e.data = d; e.hold = 8'(h);
        rq[i][rq_wr[i] % 256] = e;
        rq_wr[i]++;
    endtask

    task automatic load();
        for (int i = 0; i < N; i++) begin
            if (!busy[i] && rq_rd[i] != rq_wr[i]) begin
                cur[i]    = rq[i][rq_rd[i] % 256];
                rq_rd[i]++;
                busy[i]   = 1'b1;
                held[i]   = 0;
                ld_cyc[i] = cyc;
            end
            req[i]   = busy[i] && cur[i].kind != 2'd1;
            wr[i]    = busy[i] ? cur[i].wr : 1'($urandom());
            addr[i]  = busy[i] ? cur[i].addr : $urandom();
            wstrb[i] = busy[i] ? cur[i].strb : 4'($urandom());
            wdata[i] = busy[i] ? cur[i].data : $urandom();
            size[i]  = 2'd2;
        end
    endtask

    task automatic step();
        bit          acc [N];
        int          k;
        int          cnt;
        int          w;
        bit          e_ok;
        bit          e_dok;
        logic [31:0] e_rd;
        @(negedge clk);
        k = cyc % 64;
        for (int i = 0; i < N; i++) begin
            if (reset) begin
                e_ok = 1'b0; e_dok = 1'b0; e_rd = 32'd0;
            end else begin
                cnt = 0;
                for (int j = 1; j <= lat_of(i); j++) cnt += int'(acc_hist[i][(cyc - j + 64) % 64]);
                e_ok  = (req[i] === 1'b1) && cnt < max_of(i) && streak[i] >= dly_of(i);
                e_dok = sch_v[i][k];
                e_rd  = (sch_v[i][k] && sch_r[i][k]) ? sch_d[i][k] : 32'd0;
            end
            chk($sformatf("addr_ok[%0d]@%0d", i, cyc), 32'(addr_ok[i]), 32'(e_ok));
            chk($sformatf("data_ok[%0d]@%0d", i, cyc), 32'(data_ok[i]), 32'(e_dok));
            chk($sformatf("rdata[%0d]@%0d", i, cyc), rdata[i], e_rd);
            if (req[i] === 1'b1 && addr_ok[i] === 1'b1) begin acc_c[i][acc_n[i] % 256] = cyc; acc_n[i]++; end
            if (data_ok[i] === 1'b1) begin dok_c[i][dok_n[i] % 256] = cyc; dok_n[i]++; end
            if (e_dok && sch_r[i][k]) rd_last[i] = rdata[i];
            if (reset) begin
                for (int j = 0; j < 64; j++) begin acc_hist[i][j] = 1'b0; sch_v[i][j] = 1'b0; end
                streak[i] = 0;
            end else begin
                acc_hist[i][k] = e_ok;
                sch_v[i][k]    = 1'b0;
                if (e_ok) begin
                    w = widx(i, addr[i]);
                    sch_v[i][(cyc + lat_of(i)) % 64] = 1'b1;
                    sch_r[i][(cyc + lat_of(i)) % 64] = !wr[i];
                    sch_d[i][(cyc + lat_of(i)) % 64] = wr[i] ? 32'd0 : mem_m[i][w];
                    if (wr[i]) begin
                        for (int b = 0; b < 4; b++)
                            if (wstrb[i][b]) mem_m[i][w][8*b +: 8] = wdata[i][8*b +: 8];
                    end
                end
                streak[i] = (req[i] !== 1'b1 || e_ok) ? 0 : streak[i] + 1;
            end
            acc[i] = e_ok;
        end
        cyc++;
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            if (busy[i]) begin
                held[i]++;
                if (acc[i] || cur[i].kind == 2'd1 || (cur[i].kind == 2'd2 && held[i] >= int'(cur[i].hold)))
                    busy[i] = 1'b0;
            end
        end
        load();
    endtask

    function automatic bit pending();
        for (int i = 0; i < N; i++) if (busy[i] || rq_rd[i] != rq_wr[i]) return 1'b1;
        return 1'b0;
    endfunction

    task automatic run_all();
        int guard;
        guard = 0;
        load();
        while (pending() && guard < 2000) begin step(); guard++; end
        chk("run_all_bound", 32'(guard < 2000), 32'd1);
        if (guard >= 2000) begin
            for (int i = 0; i < N; i++) begin busy[i] = 1'b0; rq_rd[i] = rq_wr[i]; end
            load();
        end
        repeat (5) step();
    endtask

    int n0, d0, n1, d1, n2;

    initial begin
        vectors = 0; miscompares = 0; cyc = 0;
        for (int i = 0; i < N; i++) begin
            rq_wr[i] = 0; rq_rd[i] = 0; busy[i] = 1'b0; held[i] = 0; streak[i] = 0;
            acc_n[i] = 0; dok_n[i] = 0; rd_last[i] = 32'd0; ld_cyc[i] = 0;
        end
        reset = 1'b1;
        load();
        step();
        step();
        reset = 1'b0;
        repeat (2) step();

        for (int i = 0; i < N; i++)
            for (int w = 0; w < 16; w++) push(i, 2'd0, 1'b1, mk_addr(i, w), 4'hF, $urandom(), 0);
        run_all();

        // Write then read back-to-back, latency 2
        n0 = acc_n[0]; d0 = dok_n[0];
        push(0, 2'd0, 1'b1, 32'h10, 4'hF, 32'hDEADBEEF, 0);
        push(0, 2'd0, 1'b0, 32'h10, 4'h0, 32'h0, 0);
        run_all();
        chk("wr_rd_data", rd_last[0], 32'hDEADBEEF);
        chk("wr_rd_b2b", 32'(ac(0, n0 + 1) - ac(0, n0)), 32'd1);
        chk("wr_lat", 32'(dc(0, d0) - ac(0, n0)), 32'd2);
        chk("rd_lat", 32'(dc(0, d0 + 1) - ac(0, n0 + 1)), 32'd2);

        // Partial strobe merge
        push(0, 2'd0, 1'b1, 32'h20, 4'hF, 32'h11223344, 0);
        push(0, 2'd0, 1'b1, 32'h20, 4'b0100, 32'h00AA0000, 0);
        push(0, 2'd0, 1'b0, 32'h20, 4'h0, 32'h0, 0);
        run_all();
        chk("strobe_merge", rd_last[0], 32'h11AA3344);

        // Queue full at L=3, MAX=2: third read waits for the cycle after the first data_ok
        n1 = acc_n[1]; d1 = dok_n[1];
        for (int w = 1; w <= 3; w++) push(1, 2'd0, 1'b0, mk_addr(1, w), 4'h0, 32'h0, 0);
        run_all();
        chk("full_third_accept", 32'(ac(1, n1 + 2) - ac(1, n1)), 32'd4);
        chk("full_after_dok", 32'(ac(1, n1 + 2) - dc(1, d1)), 32'd1);
        chk("full_resp_count", 32'(dok_n[1] - d1), 32'd3);

        // Accept delay 2 with an abandoned attempt first
        n2 = acc_n[2];
        push(2, 2'd2, 1'b0, mk_addr(2, 3), 4'h0, 32'h0, 2);
        push(2, 2'd1, 1'b0, 32'h0, 4'h0, 32'h0, 0);
        push(2, 2'd0, 1'b0, mk_addr(2, 5), 4'h0, 32'h0, 0);
        run_all();
        chk("delay_accepts", 32'(acc_n[2] - n2), 32'd1);
        chk("delay_third_cycle", 32'(ac(2, n2) - ld_cyc[2]), 32'd2);

        // Aliasing with ADDR_WIDTH=4
        push(1, 2'd0, 1'b1, 32'h04, 4'hF, 32'h5, 0);
        push(1, 2'd0, 1'b0, 32'h44, 4'h0, 32'h0, 0);
        run_all();
        chk("alias_data", rd_last[1], 32'h5);

        // Reset with two reads in flight
        n1 = acc_n[1]; d1 = dok_n[1];
        push(1, 2'd0, 1'b0, 32'h04, 4'h0, 32'h0, 0);
        push(1, 2'd0, 1'b0, 32'h08, 4'h0, 32'h0, 0);
        load();
        step();
        step();
        reset = 1'b1;
        for (int i = 0; i < N; i++) busy[i] = 1'b0;
        load();
        step();
        reset = 1'b0;
        repeat (6) step();
        chk("rst_accepts", 32'(acc_n[1] - n1), 32'd2);
        chk("rst_no_dok", 32'(dok_n[1] - d1), 32'd0);
        push(1, 2'd0, 1'b0, 32'h04, 4'h0, 32'h0, 0);
        run_all();
        chk("rst_mem_kept", rd_last[1], 32'h5);

        for (int n = 0; n < 360; n++) begin
            int i;
            int r;
            i = int'($urandom_range(0, N - 1));
            r = int'($urandom_range(0, 9));
            if (r == 0) push(i, 2'd1, 1'b0, 32'h0, 4'h0, 32'h0, 0);
            else push(i, 2'd0, r < 5, mk_addr(i, int'($urandom_range(0, 15))), 4'($urandom()), $urandom(), 0);
        end
        run_all();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
